// File: rtl/instruction_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_prefetch_buffer
//  Description : Instruction prefetch queue between the instruction ROM port
//                and the fetch stage. Issues sequential ROM reads ahead of the
//                pipeline, buffers {instruction, pc} in an in-order FIFO and
//                flushes/restarts on a taken branch.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_prefetch_buffer #(
   parameter int                     DEPTH           = 4,
   parameter int                     MAX_OUTSTANDING = 2,
   parameter int                     ADDR_WIDTH      = 16,
   parameter int                     DATA_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC        = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  rom_req,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic                  rom_ready,
   input  logic                  rom_valid,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   input  logic                  take,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_rom_data,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [ADDR_WIDTH-1:0] out_next_pc
);

   localparam int                    PTR_W     = $clog2(DEPTH);
   localparam int                    CNT_W     = PTR_W + 1;
   localparam logic [CNT_W:0]        C_DEPTH   = (CNT_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0]      C_MAX_OUT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0]      C_CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0]      C_PTR_ONE = PTR_W'(1);
   localparam logic [ADDR_WIDTH-1:0] C_PC_STEP = ADDR_WIDTH'(4);

   // Instruction FIFO storage (not reset: outputs are gated by out_valid)
   logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];
   // PC of each accepted request; inflight never exceeds MAX_OUTSTANDING <= DEPTH,
   // so a DEPTH-entry ring with power-of-two pointers is always large enough.
   logic [ADDR_WIDTH-1:0] resp_pc_q   [DEPTH];

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      inflight_q, inflight_d;
   logic [CNT_W-1:0]      discard_q, discard_d;

   logic [CNT_W:0]        credit_used;
   logic                  handshake;
   logic                  resp_keep;
   logic                  resp_drop;
   logic                  head_pop;

   // Slots already committed: buffered words plus kept (non-discarded) requests
   assign credit_used = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, discard_q};

   assign rom_req     = !reset && !redirect && (inflight_q < C_MAX_OUT) && (credit_used < C_DEPTH);
   assign rom_address = fetch_pc_q;
   assign handshake   = rom_req && rom_ready;

   assign resp_keep   = rom_valid && !reset && !redirect && (discard_q == '0);
   assign resp_drop   = rom_valid && !redirect && (discard_q != '0);
   assign out_valid   = (count_q != '0);
   assign head_pop    = take && out_valid && !redirect;

   assign out_rom_data = out_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign out_pc       = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
   assign out_next_pc  = out_valid ? (fifo_pc_q[rd_ptr_q] + C_PC_STEP) : '0;

   // Next-state computation; redirect overrides issue, response and consume
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      resp_wr_d  = resp_wr_q;
      resp_rd_d  = resp_rd_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      if (redirect) begin
         // rom_req is low here, so no handshake term; a same-cycle response is dropped
         fetch_pc_d = redirect_target;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         inflight_d = inflight_q - CNT_W'(rom_valid);
         discard_d  = inflight_q - CNT_W'(rom_valid);
         if (rom_valid) begin
            resp_rd_d = resp_rd_q + C_PTR_ONE;
         end
      end else begin
         if (handshake) begin
            fetch_pc_d = fetch_pc_q + C_PC_STEP;
            resp_wr_d  = resp_wr_q + C_PTR_ONE;
         end
         if (rom_valid) begin
            resp_rd_d = resp_rd_q + C_PTR_ONE;
         end
         inflight_d = inflight_q + CNT_W'(handshake) - CNT_W'(rom_valid);
         if (resp_drop) begin
            discard_d = discard_q - C_CNT_ONE;
         end
         if (resp_keep) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
         end
         if (head_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
         end
         count_d = count_q + CNT_W'(resp_keep) - CNT_W'(head_pop);
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         resp_wr_q  <= '0;
         resp_rd_q  <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         resp_wr_q  <= resp_wr_d;
         resp_rd_q  <= resp_rd_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   // Data storage: record request PCs and write kept responses at the FIFO tail
   always_ff @(posedge clk) begin
      if (handshake) begin
         resp_pc_q[resp_wr_q] <= fetch_pc_q;
      end
      if (resp_keep) begin
         fifo_data_q[wr_ptr_q] <= rom_data;
         fifo_pc_q[wr_ptr_q]   <= resp_pc_q[resp_rd_q];
      end
   end

endmodule
`default_nettype wire
